data_pack_switch: RTL

- Parametrised successor to the readout data switch.
- Accepts a stream of single data words and event headers and packs LANES data words into one FIFO entry. A header is formatted as {header, MARKER} in its own entry.
- Sits between the readout control/hit serialiser and the output FIFO write port.
- Adds partial-pack padding, explicit flush, a small skid buffer with input back-pressure, and an emitted-entry counter.

---
 rtl/data_pack_pkg.sv | 42 ++++
 rtl/pack_skid_fifo.sv | 53 +++++
 rtl/data_pack_switch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/data_pack_pkg.sv
// Shared constants and helpers for the data packing switch: default marker
// and pad words, the entry-width computation and the partial-pack padder.
package data_pack_pkg;

    // Upper bounds for the generic padding helper. Any configuration must
    // satisfy WORD_W <= PACK_MAX_WORD_W and LANES <= PACK_MAX_LANES.
    localparam int PACK_MAX_WORD_W = 32;
    localparam int PACK_MAX_LANES  = 8;
    localparam int PACK_MAX_W      = PACK_MAX_WORD_W * PACK_MAX_LANES;

    localparam int          DEF_WORD_W = 12;
    localparam int          DEF_LANES  = 3;
    localparam logic [11:0] DEF_MARKER = 12'hEC5;
    localparam logic [11:0] DEF_FILL   = 12'hFFF;

    // Width of one FIFO entry: LANES words side by side, lane 0 in the LSBs.
    function automatic int out_width(input int word_w, input int lanes);
        return word_w * lanes;
    endfunction

    // Returns acc with every lane whose index is >= idx replaced by fill.
    // The loop bounds are constants, so this unrolls into a per-bit mux.
    function automatic logic [PACK_MAX_W-1:0] pad_pack(
        input logic [PACK_MAX_W-1:0]      acc,
        input int                         idx,
        input int                         word_w,
        input int                         lanes,
        input logic [PACK_MAX_WORD_W-1:0] fill
    );
        logic [PACK_MAX_W-1:0] r;
        r = acc;
        for (int l = 0; l < PACK_MAX_LANES; l++) begin
            for (int j = 0; j < PACK_MAX_WORD_W; j++) begin
                if (l < lanes && j < word_w && l >= idx) begin
                    r[l * word_w + j] = fill[j];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pack_skid_fifo.sv
// Small register-array skid buffer: up to two pushes and one pop per cycle,
// with head, empty flag and free-slot count all derived from registers.
module pack_skid_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 push_cnt,
    input  logic [WIDTH-1:0]           push0,
    input  logic [WIDTH-1:0]           push1,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;

    assign head  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign free  = (AW+1)'(DEPTH) - count_reg;

    // Storage writes; push0 always lands before push1 so entry order holds.
    always_ff @(posedge clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr_reg] <= push0;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr_reg + AW'(1)] <= push1;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push_cnt);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push_cnt) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/data_pack_switch.sv
// Packs LANES data words per FIFO entry, emits headers as {header, MARKER},
// pads partial packs with FILL on header or flush, and drives the FIFO write
// port through a skid buffer that back-pressures the input.
module data_pack_switch
    import data_pack_pkg::*;
#(
    parameter int                WORD_W    = DEF_WORD_W,
    parameter int                LANES     = DEF_LANES,
    parameter logic [WORD_W-1:0] MARKER    = WORD_W'(DEF_MARKER),
    parameter logic [WORD_W-1:0] FILL      = WORD_W'(DEF_FILL),
    parameter int                OUT_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          In_Valid,
    input  logic                          In_Is_Header,
    input  logic [(LANES-1)*WORD_W-1:0]   In_Data,
    output logic                          In_Ready,
    input  logic                          Flush,
    input  logic                          Full,
    output logic [LANES*WORD_W-1:0]       FifoIn,
    output logic                          winc_out,
    output logic [15:0]                   Entry_Count
);
    localparam int OUT_W = out_width(WORD_W, LANES);
    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic [OUT_W-1:0]  acc_reg, acc_next, acc_mid, pad_mid;
    logic [IDX_W-1:0]  idx_reg, idx_next, idx_mid;
    logic              pend_reg, pend_next;
    logic              alive_reg;
    logic              complete, accept, ready_ok, flush_req;
    logic [1:0]        push_cnt;
    logic [OUT_W-1:0]  push0, push1, hdr_entry, head;
    logic              empty, pop;
    logic [CNT_W-1:0]  free;
    logic [WORD_W-1:0] word;

    // Readiness comes only from registers: room for a worst-case double push,
    // out of reset, and no deferred flush waiting for space.
    assign ready_ok  = (free >= CNT_W'(2));
    assign In_Ready  = alive_reg && ready_ok && !pend_reg;
    assign accept    = In_Valid && In_Ready;
    assign word      = In_Data[WORD_W-1:0];
    assign hdr_entry = {In_Data, MARKER};
    assign flush_req = Flush || pend_reg;
    assign pop       = !Full && !empty;

    // Accumulator as it stands after any data word accepted this cycle.
    always_comb begin
        acc_mid  = acc_reg;
        idx_mid  = idx_reg;
        complete = 1'b0;
        if (accept && !In_Is_Header) begin
            acc_mid[idx_reg*WORD_W +: WORD_W] = word;
            if (idx_reg == IDX_W'(LANES-1)) begin
                complete = 1'b1;
            end else begin
                idx_mid = idx_reg + IDX_W'(1);
            end
        end
    end

    // Push selection: full pack, padded partial then header, or padded flush.
    // A flush that arrives without room is deferred until two slots are free.
    always_comb begin
        pad_mid   = OUT_W'(pad_pack(PACK_MAX_W'(acc_mid), int'(idx_mid), WORD_W, LANES,
                                    PACK_MAX_WORD_W'(FILL)));
        push_cnt  = 2'd0;
        push0     = '0;
        push1     = '0;
        acc_next  = acc_mid;
        idx_next  = idx_mid;
        pend_next = pend_reg;
        if (accept && In_Is_Header) begin
            if (idx_reg != '0) begin
                push_cnt = 2'd2;
                push0    = pad_mid;
                push1    = hdr_entry;
            end else begin
                push_cnt = 2'd1;
                push0    = hdr_entry;
            end
            acc_next  = '0;
            idx_next  = '0;
            pend_next = 1'b0;
        end else if (complete) begin
            push_cnt  = 2'd1;
            push0     = acc_mid;
            acc_next  = '0;
            idx_next  = '0;
            pend_next = 1'b0;
        end else if (flush_req) begin
            if (ready_ok) begin
                if (idx_mid != '0) begin
                    push_cnt = 2'd1;
                    push0    = pad_mid;
                end
                acc_next  = '0;
                idx_next  = '0;
                pend_next = 1'b0;
            end else begin
                pend_next = 1'b1;
            end
        end
    end

    // Packing state registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            pend_reg  <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            pend_reg  <= pend_next;
            alive_reg <= 1'b1;
        end
    end

    pack_skid_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_skid (
        .clk      (Clk),
        .rst_n    (Reset),
        .push_cnt (push_cnt),
        .push0    (push0),
        .push1    (push1),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .free     (free)
    );

    // Registered FIFO write port; everything freezes while downstream is full.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            FifoIn      <= '0;
            winc_out    <= 1'b0;
            Entry_Count <= '0;
        end else if (!Full) begin
            winc_out <= !empty;
            if (!empty) begin
                FifoIn <= head;
                if (Entry_Count != 16'hFFFF) begin
                    Entry_Count <= Entry_Count + 16'd1;
                end
            end
        end
    end

    no_overflow: assert property (@(posedge Clk) disable iff (!Reset)
                                  (push_cnt != 2'd0) |-> ready_ok);

endmodule
